// File: rtl/load_store_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit: funct3 access
//               size/sign encodings and the LSU state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package load_store_unit_pkg;

  // funct3 encodings (instr[14:12]) for loads and stores
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
//==============================================================================
// Module      : lsu_align
// Description : Purely combinational data-path helper for the load/store unit.
//               Generates byte enables, replicates store data across lanes,
//               extracts and extends load data, and flags misaligned
//               accesses and illegal funct3 codes.
// Ports       : we        - 1 = store, 0 = load
//               funct3    - access size/sign
//               addr_lo   - byte offset within the word
//               wdata     - raw store data
//               rdata     - raw bus read word
//               be        - byte enables
//               wdata_rep - lane-replicated store data
//               rdata_fmt - extracted and extended load result
//               misalign  - address not aligned to the access size
//               illegal   - funct3 not valid for this access direction
// Revision    : 1.0 - initial release
//==============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] w_lane;

  // Shift the addressed byte/halfword down to bit 0
  assign w_lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata_fmt = 32'h0;
    misalign  = 1'b0;
    illegal   = 1'b0;

    case (funct3)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      LSU_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned variants only exist for loads
    if (we && ((funct3 == LSU_BU) || (funct3 == LSU_HU))) begin
      illegal = 1'b1;
    end

    case (funct3)
      LSU_B:   rdata_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
      LSU_BU:  rdata_fmt = {24'h0, w_lane[7:0]};
      LSU_H:   rdata_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
      LSU_HU:  rdata_fmt = {16'h0, w_lane[15:0]};
      LSU_W:   rdata_fmt = w_lane;
      default: rdata_fmt = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Captures a load/store request, checks it,
//               runs a req/ready handshake on the data bus with a timeout and
//               returns formatted load data with a one-cycle completion pulse.
// Ports       : clk, reset (async, active-high)
//               ls_req/ls_we/ls_funct3/ls_addr/ls_wdata - request from control
//               ls_rdata/ls_done/ls_err/ls_busy        - result / status
//               bus_req/bus_we/bus_addr/bus_be/bus_wdata - bus request side
//               bus_rdata/bus_ready                    - bus response side
// Revision    : 1.0 - initial release
//==============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic              ls_busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  localparam int                c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  lsu_state_e         r_state;
  lsu_state_e         w_next;
  logic [2:0]         r_funct3;
  logic [1:0]         r_addr_lo;
  logic [c_cnt_w-1:0] r_cnt;

  logic [2:0]         w_sel_funct3;
  logic [1:0]         w_sel_addr_lo;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_rdata_fmt;
  logic               w_misalign;
  logic               w_illegal;
  logic               w_start;
  logic               w_start_err;

  // In IDLE the helper checks the incoming request; afterwards it formats
  // read data using the captured size and offset.
  assign w_sel_funct3  = (r_state == IDLE) ? ls_funct3    : r_funct3;
  assign w_sel_addr_lo = (r_state == IDLE) ? ls_addr[1:0] : r_addr_lo;

  assign w_start     = (r_state == IDLE) && ls_req;
  assign w_start_err = w_misalign || w_illegal;

  lsu_align u_align (
    .we        (ls_we),
    .funct3    (w_sel_funct3),
    .addr_lo   (w_sel_addr_lo),
    .wdata     (ls_wdata),
    .rdata     (bus_rdata),
    .be        (w_be),
    .wdata_rep (w_wdata_rep),
    .rdata_fmt (w_rdata_fmt),
    .misalign  (w_misalign),
    .illegal   (w_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and status outputs; outputs decode the state directly so a
  // reset drops bus_req without waiting for a clock edge.
  always_comb begin
    w_next  = r_state;
    bus_req = 1'b0;
    ls_done = 1'b0;
    ls_err  = 1'b0;
    ls_busy = 1'b1;
    case (r_state)
      IDLE: begin
        ls_busy = 1'b0;
        if (ls_req) begin
          w_next = w_start_err ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        bus_req = 1'b1;
        if (bus_ready) begin
          w_next = DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_next = ERR;
        end
      end
      ERR: begin
        ls_done = 1'b1;
        ls_err  = 1'b1;
        w_next  = IDLE;
      end
      DONE: begin
        ls_done = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture and bus-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
    end else if (w_start) begin
      r_funct3  <= ls_funct3;
      r_addr_lo <= ls_addr[1:0];
      // Rejected requests leave the bus registers untouched
      if (!w_start_err) begin
        bus_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
        bus_we    <= ls_we;
        bus_be    <= w_be;
        bus_wdata <= w_wdata_rep;
      end
    end
  end

  // Timeout counter: counts ACCESS cycles without ready, cleared in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && !bus_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Load result, held until the next successful load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ls_rdata <= 32'h0;
    end else if ((r_state == ACCESS) && bus_ready && !bus_we) begin
      ls_rdata <= w_rdata_fmt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        ls_err;
  logic        ls_busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int checks = 0;
  int errors = 0;

  load_store_unit #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_funct3 (ls_funct3),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_done   (ls_done),
    .ls_err    (ls_err),
    .ls_busy   (ls_busy),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One successful access with bus_ready already high: req at edge N,
  // bus_req in cycle N+1, ls_done in cycle N+2.
  task automatic access_ok(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
    ls_req    = 1'b1;
    ls_we     = we;
    ls_funct3 = f3;
    ls_addr   = addr;
    ls_wdata  = wdata;
    bus_rdata = rdata;
    bus_ready = 1'b1;
    tick();
    ls_req = 1'b0;
    check({tag, ".bus_req"},   {31'b0, bus_req}, 32'd1);
    check({tag, ".bus_we"},    {31'b0, bus_we},  {31'b0, we});
    check({tag, ".bus_addr"},  bus_addr,         exp_addr);
    check({tag, ".bus_be"},    {28'b0, bus_be},  {28'b0, exp_be});
    check({tag, ".bus_wdata"}, bus_wdata,        exp_wdata);
    check({tag, ".early_done"}, {31'b0, ls_done}, 32'd0);
    tick();
    check({tag, ".done"},      {31'b0, ls_done}, 32'd1);
    check({tag, ".err"},       {31'b0, ls_err},  32'd0);
    check({tag, ".req_off"},   {31'b0, bus_req}, 32'd0);
    check({tag, ".rdata"},     ls_rdata,         exp_rdata);
    tick();
    check({tag, ".idle"},      {31'b0, ls_busy}, 32'd0);
  endtask

  int hi_cnt;
  int done_cnt;

  initial begin
    reset     = 1'b1;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_funct3 = 3'b000;
    ls_addr   = 32'h0;
    ls_wdata  = 32'h0;
    bus_rdata = 32'h0;
    bus_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.bus_req", {31'b0, bus_req}, 32'd0);
    check("rst.busy",    {31'b0, ls_busy}, 32'd0);
    check("rst.done",    {31'b0, ls_done}, 32'd0);
    check("rst.be",      {28'b0, bus_be},  32'd0);
    check("rst.rdata",   ls_rdata,         32'h0);
    reset = 1'b0;
    tick();

    // Stores: ls_rdata must stay at its reset value
    access_ok("SW",  1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,
              32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
    access_ok("SB",  1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,
              32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0);
    access_ok("SH",  1'b1, 3'b001, 32'h206, 32'h00001234, 32'h0,
              32'h204, 4'b1100, 32'h12341234, 32'h0);

    // Loads from 0x302 of word 0x12F05678
    access_ok("LB",  1'b0, 3'b000, 32'h302, 32'h0, 32'h12F05678,
              32'h300, 4'b0100, 32'h0, 32'hFFFFFFF0);
    access_ok("LBU", 1'b0, 3'b100, 32'h302, 32'h0, 32'h12F05678,
              32'h300, 4'b0100, 32'h0, 32'h000000F0);
    access_ok("LH",  1'b0, 3'b001, 32'h302, 32'h0, 32'h12F05678,
              32'h300, 4'b1100, 32'h0, 32'h000012F0);

    // Misaligned LW: error in N+1, no bus activity, ls_rdata held
    bus_ready = 1'b0;
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_funct3 = 3'b010;
    ls_addr   = 32'h401;
    tick();
    ls_req = 1'b0;
    check("misal.bus_req", {31'b0, bus_req}, 32'd0);
    check("misal.done",    {31'b0, ls_done}, 32'd1);
    check("misal.err",     {31'b0, ls_err},  32'd1);
    check("misal.rdata",   ls_rdata,         32'h000012F0);
    check("misal.addr",    bus_addr,         32'h300);
    tick();
    check("misal.idle",    {31'b0, ls_busy}, 32'd0);
    check("misal.req2",    {31'b0, bus_req}, 32'd0);

    // Illegal store funct3 (LBU encoding on a store)
    ls_req    = 1'b1;
    ls_we     = 1'b1;
    ls_funct3 = 3'b100;
    ls_addr   = 32'h800;
    tick();
    ls_req = 1'b0;
    check("ills.bus_req", {31'b0, bus_req}, 32'd0);
    check("ills.err",     {31'b0, ls_err},  32'd1);
    tick();

    // Illegal load funct3 011
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_funct3 = 3'b011;
    ls_addr   = 32'h800;
    tick();
    ls_req = 1'b0;
    check("illl.done", {31'b0, ls_done}, 32'd1);
    check("illl.err",  {31'b0, ls_err},  32'd1);
    tick();

    // Timeout: 16 ACCESS cycles, then error; second request ignored
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_funct3 = 3'b010;
    ls_addr   = 32'h500;
    tick();
    ls_req   = 1'b0;
    hi_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus_req) hi_cnt++;
      if (ls_done) done_cnt++;
      if (i == 4) begin
        ls_req  = 1'b1;
        ls_addr = 32'h600;
      end
      if (i == 5) ls_req = 1'b0;
      tick();
    end
    check("to.req_cycles", hi_cnt,            32'd16);
    check("to.no_early",   done_cnt,          32'd0);
    check("to.done",       {31'b0, ls_done},  32'd1);
    check("to.err",        {31'b0, ls_err},   32'd1);
    check("to.req_off",    {31'b0, bus_req},  32'd0);
    check("to.addr_held",  bus_addr,          32'h500);
    check("to.rdata",      ls_rdata,          32'h000012F0);
    tick();
    check("to.idle",       {31'b0, ls_busy},  32'd0);

    // Reset in the 3rd ACCESS cycle
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_funct3 = 3'b010;
    ls_addr   = 32'h700;
    tick();
    ls_req = 1'b0;
    tick();
    tick();
    check("rmid.req_before", {31'b0, bus_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rmid.req_async",  {31'b0, bus_req}, 32'd0);
    check("rmid.busy_async", {31'b0, ls_busy}, 32'd0);
    tick();
    check("rmid.no_done",    {31'b0, ls_done}, 32'd0);
    check("rmid.rdata",      ls_rdata,         32'h0);
    reset = 1'b0;
    tick();

    // Normal access after reset: LHU from 0x702 of 0x80010000
    access_ok("LHU", 1'b0, 3'b101, 32'h702, 32'h0, 32'h80010000,
              32'h700, 4'b1100, 32'h0, 32'h00008001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage downstream of the multicycle control unit. It consumes the busWe/strb (funct3) intent plus the ALU-computed address and the store data.
- Runs a request/ready handshake to the data bus and produces byte-lane enables and replicated write data.
- Returns sign- or zero-extended load data for the register-file writeback mux.
- Flags misaligned accesses, illegal funct3 and bus timeouts instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles waiting for bus_ready before the access aborts with an error.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ls_req  in  1  start-access pulse; sampled only in IDLE
- ls_we  in  1  1 = store, 0 = load
- ls_funct3  in  3  access size/sign (instr[14:12])
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data (rs2)
- ls_rdata  out  32  formatted load result; held until the next completion
- ls_done  out  1  one-cycle completion pulse
- ls_err  out  1  valid with ls_done: misalign, illegal funct3 or timeout
- ls_busy  out  1  high in any state other than IDLE
- bus_req  out  1  bus request, held until bus_ready or timeout
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data; valid when bus_ready = 1
- bus_ready  in  1  access-complete strobe

Behaviour:
- Reset is asynchronous and takes effect immediately.
  - State goes to IDLE.
  - bus_req, bus_we, ls_done, ls_err and ls_busy go to 0.
  - bus_be, bus_addr, bus_wdata and ls_rdata go to 0.
  - The timeout counter goes to 0.
  - A reset mid-access drops bus_req with no completion pulse.
- IDLE: when ls_req = 1 at a clock edge, capture we, funct3, addr and wdata, then check the captured values.
  - Illegal funct3 (error path):
    - loads: 011, 110 or 111;
    - stores: any funct3 other than 000, 001 or 010.
  - Misalignment (error path): halfword access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Any error condition: next state is ERR.
  - Otherwise: next state is ACCESS, and bus_addr, bus_we, bus_be and bus_wdata are registered at this same edge.
- ACCESS: bus_req = 1, and bus_addr/bus_we/bus_be/bus_wdata are held stable.
  - bus_ready = 1: format and capture bus_rdata into ls_rdata (loads only) and go to DONE.
  - Each cycle without ready increments the counter.
  - Counter reaches TIMEOUT_CYCLES - 1 without ready: go to ERR.
- ERR: one cycle with ls_done = 1 and ls_err = 1; bus_req = 0; ls_rdata is unchanged. Next state is IDLE.
- DONE: one cycle with ls_done = 1 and ls_err = 0. Next state is IDLE.
- ls_req is ignored in every state except IDLE; there is no queueing.
- An ls_req in the cycle of ls_done is ignored, because the FSM is not yet in IDLE. Back-to-back throughput is 1 access per 3 cycles with zero-wait memory.
- Latency with zero-wait memory (bus_ready = 1 in the first ACCESS cycle): ls_req sampled at edge N, bus_req high in cycle N+1, ls_done high in cycle N+2.
- Latency for the error paths: ls_done/ls_err high in cycle N+1, and no bus activity occurs.
- Timeout: ls_done and ls_err are high exactly TIMEOUT_CYCLES + 1 cycles after the capture edge.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1], 1'b0}.
  - SW: 4'b1111.
  - Loads: same pattern as the corresponding store size.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load formatting: lane = bus_rdata >> (8 × addr[1:0]).
  - LB: sign-extend lane[7:0].
  - LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0].
  - LHU: zero-extend lane[15:0].
  - LW: unmodified.
- Stores never modify ls_rdata.
- A bus_ready seen outside ACCESS is ignored.

Decomposition:
- Shared defines package holds:
  - funct3 constants: LSU_B = 3'b000, LSU_H = 3'b001, LSU_W = 3'b010, LSU_BU = 3'b100, LSU_HU = 3'b101;
  - typedef enum lsu_state_e {IDLE, ACCESS, ERR, DONE}.
- One natural combinational sub-module, lsu_align. It contains the byte-enable generation, store-data replication, load extract/extend and the misalign/illegal checks.
- load_store_unit contains the FSM, the capture registers and the timeout counter.

Test Plan:
- SW: addr 0x104, data 0xDEADBEEF, ready in the first ACCESS cycle -> bus_be = 1111, bus_addr = 0x104, bus_wdata = 0xDEADBEEF, bus_we = 1; ls_done in cycle N+2 with ls_err = 0.
- SB: addr 0x203, data 0x000000A5 -> bus_be = 1000, bus_wdata = 0xA5A5A5A5, bus_addr = 0x200.
- LB vs LBU: addr 0x302, bus_rdata 0x12F0_5678 -> LB gives ls_rdata 0xFFFFFFF0, LBU gives 0x000000F0.
  - LH: addr 0x302, same bus_rdata -> 0x000012F0.
- Misaligned LW: addr 0x401 -> no bus_req ever, ls_done = ls_err = 1 in cycle N+1, ls_rdata unchanged.
- Timeout: bus_ready held at 0 with TIMEOUT_CYCLES = 16 -> bus_req high for 16 cycles, then ls_done = ls_err = 1.
  - A second ls_req pulsed mid-access is ignored.
- Reset asserted in the 3rd ACCESS cycle -> bus_req falls immediately without waiting for clk, no ls_done, and the next ls_req proceeds normally.
